// File: rtl/dbus_responder.sv
// Data-bus responder: serves CPU loads/stores from an on-chip single-port synchronous RAM.
// Latency: loads complete 1+READ_WAIT cycles after stb; stores after WRITE_WAIT (0 when buffered).
// Backpressure: stall held until completion; dropping stb while waiting abandons the request.
// Optional feature macro DBUS_RESP_WBUF_EN adds a one-entry posted write buffer.
module dbus_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int unsigned READ_WAIT  = 0,
  parameter int unsigned WRITE_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  mask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RWAIT, RRESP, WWAIT} stateT;

  stateT                 state, stateNext;
  logic [3:0]            cnt, cntNext;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [31:0]           ramQ;
  logic                  ramRe, ramWe;
  logic [ADDR_WIDTH-1:0] ramIdx;
  logic [31:0]           ramWdata;
  logic [3:0]            ramMask;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic                  inWin;
  logic                  startRead;
  logic                  unusedAddrBits;

  assign wordIdx        = addr[ADDR_WIDTH+1:2];
  assign inWin          = (addr[31:ADDR_WIDTH+2] == BASE[31:ADDR_WIDTH+2]);
  assign unusedAddrBits = ^addr[1:0];

`ifdef DBUS_RESP_WBUF_EN
  logic                  bufVld, bufLoad;
  logic [ADDR_WIDTH-1:0] bufIdx;
  logic [31:0]           bufDat;
  logic [3:0]            bufMask;
  logic                  unusedWriteWait;

  assign unusedWriteWait = (WRITE_WAIT != 0);
`endif

  // Next-state, RAM port control and bus outputs; reset forces everything quiet.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stall     = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    ramRe     = 1'b0;
    ramWe     = 1'b0;
    ramIdx    = wordIdx;
    ramWdata  = wdata;
    ramMask   = mask;
    startRead = 1'b0;
`ifdef DBUS_RESP_WBUF_EN
    bufLoad   = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef DBUS_RESP_WBUF_EN
        if (bufVld) begin
          // Drain owns the RAM port this cycle; a new request waits one cycle.
          ramWe    = 1'b1;
          ramIdx   = bufIdx;
          ramWdata = bufDat;
          ramMask  = bufMask;
          stall    = stb;
        end else if (stb && we) begin
          // Out-of-window stores are dropped, never buffered.
          bufLoad = inWin;
          err     = ~inWin;
        end else begin
          startRead = stb;
        end
`else
        if (stb && we) begin
          if (WRITE_WAIT == 0) begin
            ramWe = inWin;
            err   = ~inWin;
          end else begin
            stall     = 1'b1;
            stateNext = WWAIT;
            cntNext   = 4'(WRITE_WAIT - 1);
          end
        end else begin
          startRead = stb;
        end
`endif
        if (startRead) begin
          stall     = 1'b1;
          ramRe     = inWin;
          stateNext = (READ_WAIT == 0) ? RRESP : RWAIT;
          cntNext   = 4'(READ_WAIT);
        end
      end
      RWAIT: begin
        if (!stb) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          stall   = 1'b1;
          cntNext = cnt - 4'd1;
          if (cnt == 4'd1) stateNext = RRESP;
        end
      end
      RRESP: begin
        if (stb) begin
          rdata = inWin ? ramQ : 32'h0;
          err   = ~inWin;
        end
        stateNext = IDLE;
      end
      WWAIT: begin
        if (!stb) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cnt != 4'd0) begin
          stall   = 1'b1;
          cntNext = cnt - 4'd1;
        end else begin
          ramWe     = inWin;
          err       = ~inWin;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (!rst) begin
      stall = 1'b0;
      rdata = '0;
      err   = 1'b0;
      ramRe = 1'b0;
      ramWe = 1'b0;
`ifdef DBUS_RESP_WBUF_EN
      bufLoad = 1'b0;
`endif
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

`ifdef DBUS_RESP_WBUF_EN
  // Posted write buffer: loads on an accepted store, empties on the drain cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bufVld <= 1'b0;
    end else if (bufLoad) begin
      bufVld  <= 1'b1;
      bufIdx  <= wordIdx;
      bufDat  <= wdata;
      bufMask <= mask;
    end else if (bufVld) begin
      bufVld <= 1'b0;
    end
  end
`endif

  // Single-port RAM: byte-masked write or registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int i = 0; i < 4; i++) begin
        if (ramMask[i]) mem[ramIdx][8*i +: 8] <= ramWdata[8*i +: 8];
      end
    end
    if (ramRe) ramQ <= mem[ramIdx];
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: two instances (slow: READ_WAIT=2/WRITE_WAIT=2, fast: 0/0).
// Expected completions are queued on issue and popped at the completion cycle.
// A reference memory tracks stored data per instance.
module tb_dbus_responder;

  localparam int RW_SLOW = 2;
  localparam int WW_SLOW = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  stallCyc;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        stbS   [2];
  logic        weS    [2];
  logic [31:0] addrS  [2];
  logic [3:0]  maskS  [2];
  logic [31:0] wdataS [2];
  logic [31:0] rdataO [2];
  logic        stallO [2];
  logic        errO   [2];

  logic [31:0] refMem [2][4096];
  expT         sb[$];
  int          nCompared = 0;
  int          nFailed   = 0;
`ifdef DBUS_RESP_WBUF_EN
  bit          bufFull [2];
`endif

  always #5 clk = ~clk;

  dbus_responder #(.ADDR_WIDTH(12), .BASE(32'h0), .READ_WAIT(RW_SLOW), .WRITE_WAIT(WW_SLOW)) dutSlow (
    .clk(clk), .rst(rst), .addr(addrS[0]), .stb(stbS[0]), .we(weS[0]), .mask(maskS[0]),
    .wdata(wdataS[0]), .rdata(rdataO[0]), .stall(stallO[0]), .err(errO[0]));

  dbus_responder #(.ADDR_WIDTH(12), .BASE(32'h0), .READ_WAIT(0), .WRITE_WAIT(0)) dutFast (
    .clk(clk), .rst(rst), .addr(addrS[1]), .stb(stbS[1]), .we(weS[1]), .mask(maskS[1]),
    .wdata(wdataS[1]), .rdata(rdataO[1]), .stall(stallO[1]), .err(errO[1]));

  function automatic int rwOf(input int d);
    return (d == 0) ? RW_SLOW : 0;
  endfunction

  function automatic int wwOf(input int d);
    return (d == 0) ? WW_SLOW : 0;
  endfunction

  // Issue one request at posedge+1 and follow it to completion; ends at posedge+1 after it.
  task automatic doReq(input string tag, input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] wd,
                       output logic [31:0] rdOut, output int stallOut);
    expT  e, got;
    int   n, word;
    logic inWin;
    inWin = (a[31:14] == 18'd0);
    word  = int'(a[13:2]);
    e.err   = ~inWin;
    e.rdata = (!w && inWin) ? refMem[d][word] : 32'h0;
    n = w ? wwOf(d) : 1 + rwOf(d);
`ifdef DBUS_RESP_WBUF_EN
    n = (w ? 0 : 1 + rwOf(d)) + (bufFull[d] ? 1 : 0);
`endif
    e.stallCyc = 8'(n);
    sb.push_back(e);
    stbS[d] = 1'b1; weS[d] = w; addrS[d] = a; maskS[d] = m; wdataS[d] = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stallO[d]) break;
      nCompared++;
      if (rdataO[d] !== 32'h0 || errO[d] !== 1'b0) begin
        nFailed++;
        $display("FAIL %s d%0d outputs while stalled: rdata=%h err=%b, want 0/0", tag, d, rdataO[d], errO[d]);
      end
      n++;
      if (n > 40) begin
        nFailed++;
        $display("FAIL %s d%0d timeout: stall still high after %0d cycles", tag, d, n);
        break;
      end
      @(posedge clk); #1;
    end
    got = sb.pop_front();
    nCompared++;
    if (n !== int'(got.stallCyc)) begin
      nFailed++;
      $display("FAIL %s d%0d stall cycles: got %0d want %0d", tag, d, n, got.stallCyc);
    end
    nCompared++;
    if (rdataO[d] !== got.rdata) begin
      nFailed++;
      $display("FAIL %s d%0d rdata: got %h want %h", tag, d, rdataO[d], got.rdata);
    end
    nCompared++;
    if (errO[d] !== got.err) begin
      nFailed++;
      $display("FAIL %s d%0d err: got %b want %b", tag, d, errO[d], got.err);
    end
    rdOut    = rdataO[d];
    stallOut = n;
    if (w && inWin) begin
      for (int i = 0; i < 4; i++) if (m[i]) refMem[d][word][8*i +: 8] = wd[8*i +: 8];
    end
`ifdef DBUS_RESP_WBUF_EN
    bufFull[d] = w && inWin;
`endif
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    stbS[0] = 1'b0;
    stbS[1] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
`ifdef DBUS_RESP_WBUF_EN
    bufFull[0] = 1'b0;
    bufFull[1] = 1'b0;
`endif
  endtask

  task automatic checkQuiet(input string tag, input int d);
    @(negedge clk);
    nCompared++;
    if (rdataO[d] !== 32'h0 || errO[d] !== 1'b0) begin
      nFailed++;
      $display("FAIL %s d%0d: rdata=%h err=%b, want 0/0", tag, d, rdataO[d], errO[d]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      stbS[d] = 1'b1; weS[d] = 1'b0; addrS[d] = 32'h14; maskS[d] = 4'hF; wdataS[d] = 32'h0;
    end
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        nCompared++;
        if (stallO[d] !== 1'b0 || rdataO[d] !== 32'h0 || errO[d] !== 1'b0) begin
          nFailed++;
          $display("FAIL reset d%0d: stall=%b rdata=%h err=%b, want 0/0/0", d, stallO[d], rdataO[d], errO[d]);
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_read_wait;
    logic [31:0] rd; int sc;
    doReq("preload5", 0, 1'b1, 32'h14, 4'hF, 32'h1234_5678, rd, sc);
    idle(1);
    doReq("read_wait", 0, 1'b0, 32'h14, 4'h0, 32'h0, rd, sc);
    nCompared++;
    if (sc !== 3 || rd !== 32'h1234_5678) begin
      nFailed++;
      $display("FAIL read_wait: stalls=%0d rdata=%h, want 3 and 12345678", sc, rd);
    end
    stbS[0] = 1'b0;
    checkQuiet("read_wait_after", 0);
    @(posedge clk); #1;
  endtask

  task automatic test_masked_write;
    logic [31:0] rd; int sc;
    doReq("mask_store", 0, 1'b1, 32'h14, 4'b0101, 32'hAABB_CCDD, rd, sc);
    doReq("mask_read", 0, 1'b0, 32'h14, 4'h0, 32'h0, rd, sc);
    nCompared++;
    if (rd !== 32'h12BB_56DD) begin
      nFailed++;
      $display("FAIL mask_value: got %h want 12bb56dd", rd);
    end
    doReq("mask0_store", 1, 1'b1, 32'h30, 4'hF, 32'h0F0F_1234, rd, sc);
    doReq("mask0_nop", 1, 1'b1, 32'h30, 4'h0, 32'hFFFF_FFFF, rd, sc);
    doReq("mask0_read", 1, 1'b0, 32'h30, 4'h0, 32'h0, rd, sc);
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int sc;
    doReq("b2b_store", 1, 1'b1, 32'h50, 4'hF, 32'hDEAD_BEEF, rd, sc);
    doReq("b2b_read", 1, 1'b0, 32'h50, 4'h0, 32'h0, rd, sc);
    nCompared++;
    if (rd !== 32'hDEAD_BEEF) begin
      nFailed++;
      $display("FAIL b2b_value: got %h want deadbeef", rd);
    end
    for (int w = 0; w < 4; w++) doReq("rnd_init", 1, 1'b1, 32'(32'h100 + 4*w), 4'hF, $urandom, rd, sc);
    for (int i = 0; i < 24; i++) begin
      doReq("rnd", 1, 1'($urandom_range(0, 1)), 32'(32'h100 + 4*$urandom_range(0, 3)),
            4'($urandom_range(0, 15)), $urandom, rd, sc);
    end
    idle(1);
  endtask

  task automatic test_abort;
    logic [31:0] rd; int sc;
    doReq("abort_pre6", 0, 1'b1, 32'h18, 4'hF, 32'h6666_0006, rd, sc);
    doReq("abort_pre7", 0, 1'b1, 32'h1C, 4'hF, 32'hCAFE_0007, rd, sc);
    idle(1);
    stbS[0] = 1'b1; weS[0] = 1'b0; addrS[0] = 32'h18;
    repeat (2) begin
      @(negedge clk);
      nCompared++;
      if (stallO[0] !== 1'b1) begin
        nFailed++;
        $display("FAIL abort_read_stall: got %b want 1", stallO[0]);
      end
      @(posedge clk); #1;
    end
    stbS[0] = 1'b0;
    checkQuiet("abort_read_drop", 0);
    @(posedge clk); #1;
    checkQuiet("abort_read_next", 0);
    @(posedge clk); #1;
    doReq("abort_read_recover", 0, 1'b0, 32'h18, 4'h0, 32'h0, rd, sc);
`ifndef DBUS_RESP_WBUF_EN
    stbS[0] = 1'b1; weS[0] = 1'b1; addrS[0] = 32'h1C; maskS[0] = 4'hF; wdataS[0] = 32'h5555_5555;
    repeat (2) begin
      @(negedge clk);
      nCompared++;
      if (stallO[0] !== 1'b1) begin
        nFailed++;
        $display("FAIL abort_write_stall: got %b want 1", stallO[0]);
      end
      @(posedge clk); #1;
    end
    stbS[0] = 1'b0;
    checkQuiet("abort_write_drop", 0);
    @(posedge clk); #1;
    doReq("abort_write_check", 0, 1'b0, 32'h1C, 4'h0, 32'h0, rd, sc);
`endif
    idle(1);
  endtask

  task automatic test_out_of_window;
    logic [31:0] rd; int sc;
    doReq("oow_pre0", 0, 1'b1, 32'h0, 4'hF, 32'hA5A5_0000, rd, sc);
    idle(1);
    doReq("oow_read", 0, 1'b0, 32'h0000_4000, 4'h0, 32'h0, rd, sc);
    stbS[0] = 1'b0;
    checkQuiet("oow_err_pulse", 0);
    @(posedge clk); #1;
    doReq("oow_store", 0, 1'b1, 32'h0000_4000, 4'hF, 32'h1111_2222, rd, sc);
    doReq("oow_check0", 0, 1'b0, 32'h0, 4'h0, 32'h0, rd, sc);
    nCompared++;
    if (rd !== 32'hA5A5_0000) begin
      nFailed++;
      $display("FAIL oow_word0: got %h want a5a50000", rd);
    end
    doReq("oow_fast_store", 1, 1'b1, 32'h8000_0030, 4'hF, 32'h7777_7777, rd, sc);
    doReq("oow_fast_read", 1, 1'b0, 32'h30, 4'h0, 32'h0, rd, sc);
    idle(1);
  endtask

  task automatic test_reset_mid_request;
    logic [31:0] rd; int sc;
    doReq("rst_pre9", 1, 1'b1, 32'h24, 4'hF, 32'h0900_0009, rd, sc);
    idle(1);
    rst = 1'b0;
    stbS[1] = 1'b1; weS[1] = 1'b1; addrS[1] = 32'h24; maskS[1] = 4'hF; wdataS[1] = 32'hBAD0_BAD0;
    @(negedge clk);
    nCompared++;
    if (stallO[1] !== 1'b0) begin
      nFailed++;
      $display("FAIL rst_stall: got %b want 0", stallO[1]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    doReq("rst_check9", 1, 1'b0, 32'h24, 4'h0, 32'h0, rd, sc);
`ifndef DBUS_RESP_WBUF_EN
    stbS[0] = 1'b1; weS[0] = 1'b1; addrS[0] = 32'h1C; maskS[0] = 4'hF; wdataS[0] = 32'h3333_3333;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    doReq("rst_check7", 0, 1'b0, 32'h1C, 4'h0, 32'h0, rd, sc);
`endif
    idle(1);
  endtask

`ifdef DBUS_RESP_WBUF_EN
  task automatic test_wbuf;
    logic [31:0] rd, old; int sc, sc2;
    doReq("wb_st1", 1, 1'b1, 32'h60, 4'hF, 32'h1111_0001, rd, sc);
    doReq("wb_st2", 1, 1'b1, 32'h64, 4'hF, 32'h2222_0002, rd, sc2);
    nCompared++;
    if (sc !== 0 || sc2 !== 1) begin
      nFailed++;
      $display("FAIL wb_store_pair: stalls %0d,%0d want 0,1", sc, sc2);
    end
    doReq("wb_read", 1, 1'b0, 32'h64, 4'h0, 32'h0, rd, sc);
    nCompared++;
    if (rd !== 32'h2222_0002 || sc !== 2) begin
      nFailed++;
      $display("FAIL wb_read_after: rdata=%h stalls=%0d want 22220002 and 2", rd, sc);
    end
    idle(1);
    old = refMem[1][26];
    doReq("wb_rst_pre", 1, 1'b1, 32'h68, 4'hF, 32'h6868_6868, rd, sc);
    idle(1);
    old = refMem[1][26];
    doReq("wb_rst_store", 1, 1'b1, 32'h68, 4'hF, 32'h0BAD_0BAD, rd, sc);
    stbS[1] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    refMem[1][26] = old;
    idle(1);
    doReq("wb_rst_check", 1, 1'b0, 32'h68, 4'h0, 32'h0, rd, sc);
    idle(1);
  endtask
`endif

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      stbS[d] = 1'b0; weS[d] = 1'b0; addrS[d] = '0; maskS[d] = '0; wdataS[d] = '0;
`ifdef DBUS_RESP_WBUF_EN
      bufFull[d] = 1'b0;
`endif
    end
    test_reset();
    test_read_wait();
    test_masked_write();
    test_back_to_back();
    test_abort();
    test_out_of_window();
    test_reset_mid_request();
`ifdef DBUS_RESP_WBUF_EN
    test_wbuf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
